// File: rtl/jfpjc_pkg.sv
// Shared types and JPEG byte constants for the scan byte unstuffer.
package jfpjc_pkg;

  typedef enum logic [1:0] {
    ST_DATA   = 2'd0,
    ST_GOT_FF = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_MARKER = 2'd3
  } state_t;

  localparam logic [7:0] JPEG_MARKER_PREFIX = 8'hFF;
  localparam logic [7:0] JPEG_STUFF_BYTE    = 8'h00;
  localparam logic [7:0] JPEG_EOI           = 8'hD9;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/jfpjc_byte_unstuffer_if.sv
// Byte-in / word-out / marker-out bundle of the unstuffer.
// Every channel is valid/ready: a transfer happens on a rising edge where both
// are high, and the sender holds its payload stable while valid && !ready.
interface jfpjc_byte_unstuffer_if #(parameter int WORD_BYTES = 4);
  logic [7:0]              byte_in;
  logic                    byte_in_valid;
  logic                    byte_in_ready;
  logic [8*WORD_BYTES-1:0] word_out;
  logic [2:0]              word_out_nbytes;
  logic                    word_out_valid;
  logic                    word_out_ready;
  logic                    marker_valid;
  logic [7:0]              marker_code;
  logic                    marker_ready;

  modport master (
    output byte_in, byte_in_valid, word_out_ready, marker_ready,
    input  byte_in_ready, word_out, word_out_nbytes, word_out_valid,
           marker_valid, marker_code
  );

  modport slave (
    input  byte_in, byte_in_valid, word_out_ready, marker_ready,
    output byte_in_ready, word_out, word_out_nbytes, word_out_valid,
           marker_valid, marker_code
  );
endinterface

// File: rtl/jfpjc_byte_packer.sv
// Big-endian byte packer: shift register, fill count, full strobe and a
// zero-padded MSB-aligned view of a partial word for flushing.
module jfpjc_byte_packer #(
  parameter int WORD_BYTES = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push,
  input  logic [7:0]              push_data,
  input  logic                    flush,
  output logic [2:0]              count,
  output logic                    full,
  output logic [8*WORD_BYTES-1:0] full_word,
  output logic [8*WORD_BYTES-1:0] partial_word
);
  localparam int W = 8 * WORD_BYTES;

  logic [W-1:0] shift;
  logic [2:0]   pad_bytes;

  assign full      = push && (count == 3'(WORD_BYTES - 1));
  assign full_word = {shift[W-9:0], push_data};
  assign pad_bytes = 3'(WORD_BYTES) - count;
  // Shifting out the pad bytes also drops stale bytes left from the last full word.
  assign partial_word = shift << {pad_bytes, 3'b000};

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      shift <= '0;
      count <= '0;
    end else if (push) begin
      shift <= {shift[W-9:0], push_data};
      count <= full ? 3'd0 : count + 3'd1;
    end
  end
endmodule

// File: rtl/jfpjc_byte_unstuffer.sv
// JPEG scan byte unstuffer: strips 0xFF00 stuffing, drops fill bytes, reports
// markers and packs data bytes into words. Optional macro JFPJC_UNSTUFF_STATS_EN.
module jfpjc_byte_unstuffer
  import jfpjc_pkg::*;
#(
  parameter int WORD_BYTES = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  jfpjc_byte_unstuffer_if.slave    bus,
  output state_t                   fsm_state
`ifdef JFPJC_UNSTUFF_STATS_EN
  ,
  output logic [15:0]              stat_stuffed_count,
  output logic [15:0]              stat_fill_count,
  output logic [7:0]               stat_marker_count
`endif
);
  localparam int W = 8 * WORD_BYTES;

  state_t       state;
  logic [W-1:0] word_q;
  logic [2:0]   nbytes_q;
  logic         word_valid_q;
  logic         marker_valid_q;
  logic [7:0]   marker_code_q;

  logic         out_free, byte_ready, accept, push, flush;
  logic [7:0]   push_data;
  logic [2:0]   pk_count;
  logic         pk_full;
  logic [W-1:0] pk_full_word, pk_partial;

  assign out_free   = !word_valid_q || bus.word_out_ready;
  assign byte_ready = !reset && (state == ST_DATA || state == ST_GOT_FF) && out_free;
  assign accept     = bus.byte_in_valid && byte_ready;
  assign push       = accept && ((state == ST_DATA   && bus.byte_in != JPEG_MARKER_PREFIX) ||
                                 (state == ST_GOT_FF && bus.byte_in == JPEG_STUFF_BYTE));
  assign push_data  = (state == ST_GOT_FF) ? JPEG_MARKER_PREFIX : bus.byte_in;
  assign flush      = (state == ST_FLUSH) && out_free;

  jfpjc_byte_packer #(.WORD_BYTES(WORD_BYTES)) u_packer (
    .clock        (clock),
    .reset        (reset),
    .push         (push),
    .push_data    (push_data),
    .flush        (flush),
    .count        (pk_count),
    .full         (pk_full),
    .full_word    (pk_full_word),
    .partial_word (pk_partial)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_DATA;
      word_q         <= '0;
      nbytes_q       <= '0;
      word_valid_q   <= 1'b0;
      marker_valid_q <= 1'b0;
      marker_code_q  <= '0;
    end else begin
      if (word_valid_q && bus.word_out_ready) word_valid_q <= 1'b0;
      if (pk_full) begin
        word_q       <= pk_full_word;
        nbytes_q     <= 3'(WORD_BYTES);
        word_valid_q <= 1'b1;
      end
      case (state)
        ST_DATA: begin
          if (accept && bus.byte_in == JPEG_MARKER_PREFIX) state <= ST_GOT_FF;
        end
        ST_GOT_FF: begin
          if (accept) begin
            if (bus.byte_in == JPEG_STUFF_BYTE) begin
              state <= ST_DATA;
            end else if (bus.byte_in != JPEG_MARKER_PREFIX) begin
              marker_code_q <= bus.byte_in;
              state         <= (pk_count != 3'd0) ? ST_FLUSH : ST_MARKER;
            end
          end
        end
        ST_FLUSH: begin
          if (out_free) begin
            word_q       <= pk_partial;
            nbytes_q     <= pk_count;
            word_valid_q <= 1'b1;
            state        <= ST_MARKER;
          end
        end
        ST_MARKER: begin
          // The marker waits until the flushed word has left, keeping stream order.
          if (!marker_valid_q && !word_valid_q) begin
            marker_valid_q <= 1'b1;
          end else if (marker_valid_q && bus.marker_ready) begin
            marker_valid_q <= 1'b0;
            state          <= ST_DATA;
          end
        end
        default: state <= ST_DATA;
      endcase
    end
  end

  assign bus.byte_in_ready   = byte_ready;
  assign bus.word_out        = word_q;
  assign bus.word_out_nbytes = nbytes_q;
  assign bus.word_out_valid  = word_valid_q;
  assign bus.marker_valid    = marker_valid_q;
  assign bus.marker_code     = marker_code_q;
  assign fsm_state           = state;

`ifdef JFPJC_UNSTUFF_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_stuffed_count <= '0;
      stat_fill_count    <= '0;
      stat_marker_count  <= '0;
    end else if (accept && state == ST_GOT_FF) begin
      if (bus.byte_in == JPEG_STUFF_BYTE)
        stat_stuffed_count <= sat_inc16(stat_stuffed_count);
      else if (bus.byte_in == JPEG_MARKER_PREFIX)
        stat_fill_count <= sat_inc16(stat_fill_count);
      else
        stat_marker_count <= sat_inc8(stat_marker_count);
    end
  end
`endif

endmodule

// File: tb/tb_jfpjc_byte_unstuffer.sv
// Directed and randomized bench for jfpjc_byte_unstuffer with a queue-based
// reference model of the unstuffing/packing rules.
module tb_jfpjc_byte_unstuffer;
  import jfpjc_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  jfpjc_byte_unstuffer_if bus ();
  state_t fsm_state;
`ifdef JFPJC_UNSTUFF_STATS_EN
  logic [15:0] stat_stuffed_count, stat_fill_count;
  logic [7:0]  stat_marker_count;
`endif

  jfpjc_byte_unstuffer dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .fsm_state (fsm_state)
`ifdef JFPJC_UNSTUFF_STATS_EN
    ,
    .stat_stuffed_count (stat_stuffed_count),
    .stat_fill_count    (stat_fill_count),
    .stat_marker_count  (stat_marker_count)
`endif
  );

  int checks = 0;
  int errors = 0;
  int words_seen = 0;

  // Expected output events in stream order: {is_marker, nbytes, payload}
  logic [35:0] exp_q[$];
  logic [7:0]  m_pend[$];
  bit          m_ff;
  bit          stall_word = 1'b0;
  bit          hold_marker = 1'b0;
  bit          rand_mode = 1'b0;
`ifdef JFPJC_UNSTUFF_STATS_EN
  int m_stuff, m_fill, m_mark;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void emit_word();
    logic [31:0] d = '0;
    for (int i = 0; i < m_pend.size(); i++) d[31-8*i -: 8] = m_pend[i];
    exp_q.push_back({1'b0, 3'(m_pend.size()), d});
    m_pend.delete();
  endfunction

  function automatic void model_push(input logic [7:0] b);
    m_pend.push_back(b);
    if (m_pend.size() == 4) emit_word();
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (!m_ff) begin
      if (b == 8'hFF) m_ff = 1'b1;
      else model_push(b);
    end else if (b == 8'h00) begin
      model_push(8'hFF);
      m_ff = 1'b0;
`ifdef JFPJC_UNSTUFF_STATS_EN
      m_stuff++;
`endif
    end else if (b == 8'hFF) begin
`ifdef JFPJC_UNSTUFF_STATS_EN
      m_fill++;
`endif
    end else begin
      if (m_pend.size() > 0) emit_word();
      exp_q.push_back({1'b1, 3'd0, 24'd0, b});
      m_ff = 1'b0;
`ifdef JFPJC_UNSTUFF_STATS_EN
      m_mark++;
`endif
    end
  endfunction

  function automatic void model_reset();
    m_pend.delete();
    exp_q.delete();
    m_ff = 1'b0;
`ifdef JFPJC_UNSTUFF_STATS_EN
    m_stuff = 0; m_fill = 0; m_mark = 0;
`endif
  endfunction

  // ---------------- downstream consumer and monitor ----------------
  always @(negedge clock) begin
    bus.word_out_ready = stall_word  ? 1'b0 : (rand_mode ? 1'($urandom_range(0, 1)) : 1'b1);
    bus.marker_ready   = hold_marker ? 1'b0 : (rand_mode ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  always @(negedge clock) begin
    logic [35:0] e;
    #4;
    if (!reset && bus.word_out_valid && bus.word_out_ready) begin
      words_seen++;
      check("word_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("word_kind", 32'(e[35]), 32'd0);
        check("word_data", bus.word_out, e[31:0]);
        check("word_nbytes", 32'(bus.word_out_nbytes), 32'(e[34:32]));
      end
    end
    if (!reset && bus.marker_valid && bus.marker_ready) begin
      check("marker_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("marker_kind", 32'(e[35]), 32'd1);
        check("marker_code", 32'(bus.marker_code), 32'(e[7:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bit done = 1'b0;
    if (rand_mode) repeat ($urandom_range(0, 2)) @(negedge clock);
    @(negedge clock);
    bus.byte_in = b;
    bus.byte_in_valid = 1'b1;
    while (!done && n < 200) begin
      #4;
      if (bus.byte_in_ready) begin
        @(posedge clock);
        #1;
        done = 1'b1;
      end else begin
        @(negedge clock);
        n++;
      end
    end
    bus.byte_in_valid = 1'b0;
    check("byte_accepted", 32'(done), 32'd1);
    if (done) model_byte(b);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() > 0 || bus.word_out_valid || bus.marker_valid) && n < 500) begin
      @(negedge clock);
      #4;
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_marker(input string tag);
    int n = 0;
    while (!bus.marker_valid && n < 50) begin
      @(negedge clock);
      #4;
      n++;
    end
    check(tag, 32'(bus.marker_valid), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_byte_in_ready"}, 32'(bus.byte_in_ready), 32'd0);
    check({tag, "_word_out"}, bus.word_out, 32'd0);
    check({tag, "_word_out_nbytes"}, 32'(bus.word_out_nbytes), 32'd0);
    check({tag, "_word_out_valid"}, 32'(bus.word_out_valid), 32'd0);
    check({tag, "_marker_valid"}, 32'(bus.marker_valid), 32'd0);
    check({tag, "_marker_code"}, 32'(bus.marker_code), 32'd0);
    check({tag, "_state"}, 32'(fsm_state), 32'(ST_DATA));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clock);
    #4;
    check_zero(tag);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    logic [7:0] t5_bytes[8];
    int words_before;
    bus.byte_in = 8'h00;
    bus.byte_in_valid = 1'b0;
    model_reset();

    // Reset state
    do_reset("reset");

    // 1: plain word, one-cycle latency after the fourth byte
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    check("t1_latency_valid", 32'(bus.word_out_valid), 32'd1);
    check("t1_word", bus.word_out, 32'h12345678);
    wait_drain("t1_drain");

    // 2: stuffed FF inside a word, no marker
    send_byte(8'h12); send_byte(8'hFF); send_byte(8'h00); send_byte(8'h34);
    send_byte(8'h56);
    check("t2_word", bus.word_out, 32'h12FF3456);
    check("t2_nbytes", 32'(bus.word_out_nbytes), 32'd4);
    wait_drain("t2_drain");
    check("t2_no_marker", 32'(bus.marker_valid), 32'd0);

    // 3: partial flush then EOI marker held pending
    hold_marker = 1'b1;
    send_byte(8'hAB); send_byte(8'hFF); send_byte(JPEG_EOI);
    wait_marker("t3_marker_seen");
    check("t3_marker_code", 32'(bus.marker_code), 32'(JPEG_EOI));
    check("t3_state", 32'(fsm_state), 32'(ST_MARKER));
    repeat (5) begin
      @(negedge clock);
      #4;
      check("t3_ready_low", 32'(bus.byte_in_ready), 32'd0);
    end
    hold_marker = 1'b0;
    wait_drain("t3_drain");

    // 4: fill bytes with nothing packed -> marker only
    do_reset("t4_reset");
    words_before = words_seen;
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hD0);
    wait_drain("t4_drain");
    check("t4_no_word", 32'(words_seen - words_before), 32'd0);
`ifdef JFPJC_UNSTUFF_STATS_EN
    check("t4_fill_count", 32'(stat_fill_count), 32'd2);
    check("t4_marker_count", 32'(stat_marker_count), 32'd1);
    check("t4_stuffed_count", 32'(stat_stuffed_count), 32'd0);
`endif

    // 5: output stall blocks input without losing bytes
    for (int i = 0; i < 8; i++) t5_bytes[i] = 8'($urandom_range(0, 254));
    stall_word = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) send_byte(t5_bytes[i]);
      end
      begin
        repeat (12) begin
          @(negedge clock);
          #4;
          if (bus.word_out_valid) check("t5_ready_low", 32'(bus.byte_in_ready), 32'd0);
        end
        check("t5_word_stalled", 32'(bus.word_out_valid), 32'd1);
        stall_word = 1'b0;
      end
    join
    wait_drain("t5_drain");

    // 6: reset mid-word and while a marker is pending
    send_byte(8'h5A); send_byte(8'hA5);
    do_reset("t6_reset_data");
    hold_marker = 1'b1;
    send_byte(8'hFF); send_byte(JPEG_EOI);
    wait_marker("t6_marker_seen");
    do_reset("t6_reset_marker");
    hold_marker = 1'b0;
    send_byte(8'hC3); send_byte(8'h3C); send_byte(8'h0F); send_byte(8'hF0);
    check("t6_fresh_word", bus.word_out, 32'hC33C0FF0);
    wait_drain("t6_drain");

    // 7: randomized stream with random backpressure
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 2) begin
        int k;
        send_byte(8'hFF);
        k = $urandom_range(0, 5);
        if (k <= 2) send_byte(8'h00);
        else if (k == 3) send_byte(8'hFF);
        else send_byte(8'($urandom_range(1, 254)));
      end else begin
        send_byte(8'($urandom_range(0, 254)));
      end
    end
    send_byte(8'hFF);
    send_byte(JPEG_EOI);
    wait_drain("t7_drain");
    rand_mode = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
